// File: rtl/snn_core_param.sv
// -----------------------------------------------------------------------------
// snn_core_param
// Purpose : two-layer inference engine. A 1-bit input image is pushed through a
//           hidden layer and an output layer. Each layer is a multiply-accumulate
//           over an external weight ROM, followed by saturation and a lookup in an
//           external activation LUT. The core reports the winning output unit
//           (argmax) and its activation.
// Ports   : clk, rst         - clock and asynchronous active-high reset
//           start_i          - begin inference (sampled only while idle)
//           abort_i          - synchronous abort back to idle, no done pulse
//           in_addr_o/in_bit_i  - input-image RAM, 1-cycle read latency
//           hw_addr_o/hw_q_i    - hidden weight ROM (h*N_IN+i), signed, 1-cycle
//           ow_addr_o/ow_q_i    - output weight ROM (o*N_HID+h), signed, 1-cycle
//           lut_addr_o/lut_q_i  - activation LUT, unsigned result, 1-cycle
//           busy_o           - high in every state except idle
//           done_o           - one-cycle pulse when digit_o/digit_prob_o update
//           digit_o          - index of the largest output activation
//           digit_prob_o     - activation value of that winning unit
// -----------------------------------------------------------------------------
module snn_core_param #(
    parameter int N_IN  = 784,
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int ACC_W = 26,
    localparam int IAW  = $clog2(N_IN),
    localparam int HWAW = $clog2(N_IN * N_HID),
    localparam int OWAW = $clog2(N_HID * N_OUT),
    localparam int DW   = $clog2(N_OUT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    output logic [IAW-1:0]  in_addr_o,
    input  logic            in_bit_i,
    output logic [HWAW-1:0] hw_addr_o,
    input  logic [7:0]      hw_q_i,
    output logic [OWAW-1:0] ow_addr_o,
    input  logic [7:0]      ow_q_i,
    output logic [10:0]     lut_addr_o,
    input  logic [7:0]      lut_q_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [DW-1:0]   digit_o,
    output logic [7:0]      digit_prob_o
);

    localparam int HIW = (N_HID > 1) ? $clog2(N_HID) : 1;

    localparam logic [IAW-1:0] I_LAST = IAW'(N_IN - 1);
    localparam logic [HIW-1:0] H_LAST = HIW'(N_HID - 1);
    localparam logic [DW-1:0]  O_LAST = DW'(N_OUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HMAC,
        S_HDRAIN,
        S_HLUT,
        S_HWR,
        S_OMAC,
        S_ODRAIN,
        S_OLUT,
        S_OWR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IAW-1:0]    iIdx_q, iIdx_d;
    logic [HIW-1:0]    hIdx_q, hIdx_d;
    logic [DW-1:0]     oIdx_q, oIdx_d;
    logic [HWAW-1:0]   hwAddr_q, hwAddr_d;
    logic [OWAW-1:0]   owAddr_q, owAddr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [10:0]       lutAddr_q, lutAddr_d;
    logic [7:0]        runMax_q, runMax_d;
    logic [DW-1:0]     runIdx_q, runIdx_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [7:0]        prob_q, prob_d;
    logic              done_q, done_d;

    // Hidden activations live in plain registers with no reset; hidA_q is the
    // hidden value read alongside the output-weight address so that both
    // operands of an output-layer product arrive in the same cycle.
    logic [7:0]        hidden_q [N_HID];
    logic [7:0]        hidA_q;

    logic              hidPhase;
    logic              macClear;
    logic              macAdd;
    logic [7:0]        macA;
    logic [7:0]        macB;
    logic signed [16:0] prod;
    logic [ACC_W-1:0]  prodExt;

    // Clamp the accumulator into an 11-bit signed window (bits 17:7) and bias it
    // by 0x400 so the most negative value maps to LUT address 0.
    function automatic logic [10:0] satAddr(input logic [ACC_W-1:0] a);
        logic [10:0] s;
        if (!a[ACC_W-1] && (|a[ACC_W-2:17])) begin
            s = 11'h3FF;
        end else if (a[ACC_W-1] && !(&a[ACC_W-2:17])) begin
            s = 11'h400;
        end else begin
            s = a[17:7];
        end
        return s + 11'h400;
    endfunction

    // Multiply-accumulate datapath. Memory data lags its address by one cycle,
    // so the first MAC cycle of a unit only clears the accumulator and the drain
    // state folds in the final product.
    always_comb begin
        hidPhase = (state_q == S_HMAC) || (state_q == S_HDRAIN);
        macClear = ((state_q == S_HMAC) && (iIdx_q == '0)) ||
                   ((state_q == S_OMAC) && (hIdx_q == '0));
        macAdd   = ((state_q == S_HMAC) && (iIdx_q != '0)) ||
                   ((state_q == S_OMAC) && (hIdx_q != '0)) ||
                   (state_q == S_HDRAIN) || (state_q == S_ODRAIN);
        macA     = hidPhase ? (in_bit_i ? 8'h7F : 8'h00) : hidA_q;
        macB     = hidPhase ? hw_q_i : ow_q_i;
        prod     = $signed({1'b0, macA}) * $signed(macB);
        prodExt  = {{(ACC_W - 17){prod[16]}}, prod};
        acc_d    = acc_q;
        if (macClear) begin
            acc_d = '0;
        end else if (macAdd) begin
            acc_d = acc_q + prodExt;
        end
    end

    // Sequencer: walks the hidden units, then the output units, tracking the
    // running argmax as each output activation comes back from the LUT.
    always_comb begin
        state_d   = state_q;
        iIdx_d    = iIdx_q;
        hIdx_d    = hIdx_q;
        oIdx_d    = oIdx_q;
        hwAddr_d  = hwAddr_q;
        owAddr_d  = owAddr_q;
        lutAddr_d = lutAddr_q;
        runMax_d  = runMax_q;
        runIdx_d  = runIdx_q;
        digit_d   = digit_q;
        prob_d    = prob_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_HMAC;
                    iIdx_d   = '0;
                    hIdx_d   = '0;
                    oIdx_d   = '0;
                    hwAddr_d = '0;
                    owAddr_d = '0;
                end
            end
            S_HMAC: begin
                if (iIdx_q == I_LAST) begin
                    state_d = S_HDRAIN;
                end else begin
                    iIdx_d   = iIdx_q + IAW'(1);
                    hwAddr_d = hwAddr_q + HWAW'(1);
                end
            end
            S_HDRAIN: begin
                state_d   = S_HLUT;
                lutAddr_d = satAddr(acc_d);
            end
            S_HLUT: begin
                state_d = S_HWR;
            end
            S_HWR: begin
                if (hIdx_q == H_LAST) begin
                    state_d = S_OMAC;
                    hIdx_d  = '0;
                end else begin
                    state_d  = S_HMAC;
                    hIdx_d   = hIdx_q + HIW'(1);
                    iIdx_d   = '0;
                    hwAddr_d = hwAddr_q + HWAW'(1);
                end
            end
            S_OMAC: begin
                if (hIdx_q == H_LAST) begin
                    state_d = S_ODRAIN;
                end else begin
                    hIdx_d   = hIdx_q + HIW'(1);
                    owAddr_d = owAddr_q + OWAW'(1);
                end
            end
            S_ODRAIN: begin
                state_d   = S_OLUT;
                lutAddr_d = satAddr(acc_d);
            end
            S_OLUT: begin
                state_d = S_OWR;
            end
            S_OWR: begin
                // Strict '>' keeps the lowest index on ties; unit 0 seeds the max.
                if ((oIdx_q == '0) || (lut_q_i > runMax_q)) begin
                    runMax_d = lut_q_i;
                    runIdx_d = oIdx_q;
                end
                if (oIdx_q == O_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_OMAC;
                    oIdx_d   = oIdx_q + DW'(1);
                    hIdx_d   = '0;
                    owAddr_d = owAddr_q + OWAW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                digit_d = runIdx_q;
                prob_d  = runMax_q;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including the result publication.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            digit_d = digit_q;
            prob_d  = prob_q;
        end
    end

    // Control and result registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iIdx_q    <= '0;
            hIdx_q    <= '0;
            oIdx_q    <= '0;
            hwAddr_q  <= '0;
            owAddr_q  <= '0;
            acc_q     <= '0;
            lutAddr_q <= '0;
            runMax_q  <= '0;
            runIdx_q  <= '0;
            digit_q   <= '0;
            prob_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iIdx_q    <= iIdx_d;
            hIdx_q    <= hIdx_d;
            oIdx_q    <= oIdx_d;
            hwAddr_q  <= hwAddr_d;
            owAddr_q  <= owAddr_d;
            acc_q     <= acc_d;
            lutAddr_q <= lutAddr_d;
            runMax_q  <= runMax_d;
            runIdx_q  <= runIdx_d;
            digit_q   <= digit_d;
            prob_q    <= prob_d;
            done_q    <= done_d;
        end
    end

    // Hidden activation store: written once per hidden unit, read every cycle
    // with the same one-cycle latency as the output-weight ROM.
    always_ff @(posedge clk) begin
        if (state_q == S_HWR) begin
            hidden_q[hIdx_q] <= lut_q_i;
        end
        hidA_q <= hidden_q[hIdx_q];
    end

    assign in_addr_o    = iIdx_q;
    assign hw_addr_o    = hwAddr_q;
    assign ow_addr_o    = owAddr_q;
    assign lut_addr_o   = lutAddr_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign digit_o      = digit_q;
    assign digit_prob_o = prob_q;

endmodule
